// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory-port arbiter: FSM state encoding,
// transaction owner encoding and the response-timer width.
package mem_arb_pkg;

  // Timer is wide enough for timeouts up to 255 cycles; it saturates rather than wraps.
  localparam int TIMER_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IMEM = 2'd1,
    OWN_DMEM = 2'd2
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data, memory and status signals around mem_arbiter.
// slave  : the arbiter itself (consumes requests, produces responses).
// master : the surrounding hart + memory model.
interface mem_arbiter_if;

  // Instruction-fetch requester
  logic        i_imem_req;
  logic [31:0] i_imem_addr;
  logic        o_imem_ready;
  logic        o_imem_valid;
  logic [31:0] o_imem_rdata;
  logic        o_imem_err;

  // Data (load/store) requester
  logic        i_dmem_ren;
  logic        i_dmem_wen;
  logic [31:0] i_dmem_addr;
  logic [31:0] i_dmem_wdata;
  logic [3:0]  i_dmem_mask;
  logic        o_dmem_ready;
  logic        o_dmem_valid;
  logic [31:0] o_dmem_rdata;
  logic        o_dmem_err;

  // Unified memory port
  logic        o_mem_req;
  logic        o_mem_wen;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_mask;
  logic        i_mem_ready;
  logic        i_mem_valid;
  logic [31:0] i_mem_rdata;

  // Status
  logic        o_busy;

  modport slave (
    input  i_imem_req, i_imem_addr,
    output o_imem_ready, o_imem_valid, o_imem_rdata, o_imem_err,
    input  i_dmem_ren, i_dmem_wen, i_dmem_addr, i_dmem_wdata, i_dmem_mask,
    output o_dmem_ready, o_dmem_valid, o_dmem_rdata, o_dmem_err,
    output o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask,
    input  i_mem_ready, i_mem_valid, i_mem_rdata,
    output o_busy
  );

  modport master (
    output i_imem_req, i_imem_addr,
    input  o_imem_ready, o_imem_valid, o_imem_rdata, o_imem_err,
    output i_dmem_ren, i_dmem_wen, i_dmem_addr, i_dmem_wdata, i_dmem_mask,
    input  o_dmem_ready, o_dmem_valid, o_dmem_rdata, o_dmem_err,
    input  o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask,
    output i_mem_ready, i_mem_valid, i_mem_rdata,
    input  o_busy
  );

endinterface

// File: rtl/mem_arb_timeout.sv
// Response timer for one memory transaction: cleared when a request is
// captured, counts each cycle enable is high, and flags expiry in the cycle
// that would be the TIMEOUT_CYCLES-th counted cycle. TIMEOUT_CYCLES = 0
// disables expiry. The count saturates instead of wrapping.
module mem_arb_timeout
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  // Count value held during the last permitted cycle.
  localparam logic [TIMER_W-1:0] LIMIT =
    (TIMEOUT_CYCLES == 0) ? '0 : TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] count_reg;
  logic [TIMER_W-1:0] count_next;

  // Next count: clear wins over enable, saturate at all-ones.
  always_comb begin
    count_next = count_reg;
    if (i_clr) begin
      count_next = '0;
    end else if (i_en && (count_reg != '1)) begin
      count_next = count_reg + 1'b1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign o_expire = (TIMEOUT_CYCLES != 0) && i_en && (count_reg == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and data requesters.
// One outstanding transaction; IDLE captures a winner, REQ presents it to
// memory, RESP waits for the answer. Responses are passed straight through
// in the cycle i_mem_valid arrives. Illegal ren&wen data requests skip REQ
// and answer with an error one cycle after capture.
// Optional build macro: MEM_ARB_RR_EN selects round-robin arbitration
// (DATA_PRIO is then ignored); undefined selects fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter bit DATA_PRIO      = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  mem_arbiter_if.slave  bus
);

  state_t      state_reg,   state_next;
  owner_t      owner_reg,   owner_next;
  logic        illegal_reg, illegal_next;

  logic        mem_wen_reg;
  logic [31:0] mem_addr_reg;
  logic [31:0] mem_wdata_reg;
  logic [3:0]  mem_mask_reg;

  logic        imem_want;
  logic        dmem_want;
  logic        illegal_req;
  logic        grant_dmem;

  logic        capture;
  logic        imem_ready;
  logic        dmem_ready;
  logic        mem_req;
  logic        done;
  logic        done_err;
  logic [31:0] done_data;
  logic        timer_clr;
  logic        timer_en;
  logic        expire;

  assign imem_want   = bus.i_imem_req;
  assign dmem_want   = bus.i_dmem_ren | bus.i_dmem_wen;
  assign illegal_req = bus.i_dmem_ren & bus.i_dmem_wen;

`ifdef MEM_ARB_RR_EN
  // 1 when the data side won the most recent grant; starts at fetch so
  // data takes the first tie.
  logic last_dmem_reg;

  // Remember who was granted last, to alternate on ties.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      last_dmem_reg <= 1'b0;
    end else if (capture) begin
      last_dmem_reg <= grant_dmem;
    end
  end

  assign grant_dmem = dmem_want & (~imem_want | ~last_dmem_reg);
`else
  assign grant_dmem = dmem_want & (~imem_want | DATA_PRIO);
`endif

  mem_arb_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (timer_clr),
    .i_en     (timer_en),
    .o_expire (expire)
  );

  // The illegal-request path never touches memory, so it does not time.
  assign timer_en = (state_reg == ST_REQ) ||
                    ((state_reg == ST_RESP) && !illegal_reg);

  // Next-state, arbitration and handshake decode.
  always_comb begin
    state_next   = state_reg;
    owner_next   = owner_reg;
    illegal_next = illegal_reg;
    capture      = 1'b0;
    imem_ready   = 1'b0;
    dmem_ready   = 1'b0;
    mem_req      = 1'b0;
    done         = 1'b0;
    done_err     = 1'b0;
    done_data    = '0;
    timer_clr    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (imem_want || dmem_want) begin
          capture   = 1'b1;
          timer_clr = 1'b1;
          if (grant_dmem) begin
            dmem_ready   = 1'b1;
            owner_next   = OWN_DMEM;
            illegal_next = illegal_req;
            state_next   = illegal_req ? ST_RESP : ST_REQ;
          end else begin
            imem_ready   = 1'b1;
            owner_next   = OWN_IMEM;
            illegal_next = 1'b0;
            state_next   = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        // The request is withdrawn in the expiry cycle, so a coincident
        // i_mem_ready does not count as an accept.
        mem_req = !expire;
        if (expire) begin
          done     = 1'b1;
          done_err = 1'b1;
        end else if (bus.i_mem_ready && bus.i_mem_valid) begin
          done      = 1'b1;
          done_data = bus.i_mem_rdata;
        end else if (bus.i_mem_ready) begin
          state_next = ST_RESP;
        end
      end

      ST_RESP: begin
        // A genuine response in the last permitted cycle beats the timeout.
        if (illegal_reg) begin
          done     = 1'b1;
          done_err = 1'b1;
        end else if (bus.i_mem_valid) begin
          done      = 1'b1;
          done_data = bus.i_mem_rdata;
        end else if (expire) begin
          done     = 1'b1;
          done_err = 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
        owner_next = OWN_NONE;
      end
    endcase

    if (done) begin
      state_next   = ST_IDLE;
      owner_next   = OWN_NONE;
      illegal_next = 1'b0;
    end
  end

  // FSM and owner registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg   <= ST_IDLE;
      owner_reg   <= OWN_NONE;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      owner_reg   <= owner_next;
      illegal_reg <= illegal_next;
    end
  end

  // Register the winner's request fields; illegal requests leave them alone.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      mem_wen_reg   <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_mask_reg  <= '0;
    end else if (capture && !(grant_dmem && illegal_req)) begin
      if (grant_dmem) begin
        mem_wen_reg   <= bus.i_dmem_wen;
        mem_addr_reg  <= bus.i_dmem_addr;
        mem_wdata_reg <= bus.i_dmem_wdata;
        mem_mask_reg  <= bus.i_dmem_mask;
      end else begin
        mem_wen_reg   <= 1'b0;
        mem_addr_reg  <= bus.i_imem_addr;
        mem_wdata_reg <= '0;
        mem_mask_reg  <= 4'hF;
      end
    end
  end

  assign bus.o_imem_ready = imem_ready;
  assign bus.o_dmem_ready = dmem_ready;

  assign bus.o_imem_valid = done && (owner_reg == OWN_IMEM);
  assign bus.o_dmem_valid = done && (owner_reg == OWN_DMEM);
  assign bus.o_imem_err   = done && done_err && (owner_reg == OWN_IMEM);
  assign bus.o_dmem_err   = done && done_err && (owner_reg == OWN_DMEM);
  assign bus.o_imem_rdata = (owner_reg == OWN_IMEM) ? done_data : '0;
  assign bus.o_dmem_rdata = (owner_reg == OWN_DMEM) ? done_data : '0;

  assign bus.o_mem_req   = mem_req;
  assign bus.o_mem_wen   = mem_wen_reg;
  assign bus.o_mem_addr  = mem_addr_reg;
  assign bus.o_mem_wdata = mem_wdata_reg;
  assign bus.o_mem_mask  = mem_mask_reg;

  assign bus.o_busy = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT_CYCLES=8, DATA_PRIO=1).
// A table of single-requester transactions is replayed cycle by cycle,
// followed by hand-written tie, continuous-tie and mid-transaction reset
// sequences. Inputs change 1 time unit after the rising edge; outputs are
// sampled on the falling edge.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .TIMEOUT_CYCLES (8),
    .DATA_PRIO      (1'b1)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int tag    = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL [seq %0d k %0d] %s: got 0x%08h, expected 0x%08h", tag, cyc, name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.i_imem_req   = 1'b0;
    bus.i_imem_addr  = '0;
    bus.i_dmem_ren   = 1'b0;
    bus.i_dmem_wen   = 1'b0;
    bus.i_dmem_addr  = '0;
    bus.i_dmem_wdata = '0;
    bus.i_dmem_mask  = '0;
    bus.i_mem_ready  = 1'b0;
    bus.i_mem_valid  = 1'b0;
    bus.i_mem_rdata  = '0;
  endtask

  task automatic chk_all_zero(input string where);
    chk({where, " imem_ready"}, bus.o_imem_ready, 0);
    chk({where, " imem_valid"}, bus.o_imem_valid, 0);
    chk({where, " imem_err"},   bus.o_imem_err,   0);
    chk({where, " imem_rdata"}, bus.o_imem_rdata, 0);
    chk({where, " dmem_ready"}, bus.o_dmem_ready, 0);
    chk({where, " dmem_valid"}, bus.o_dmem_valid, 0);
    chk({where, " dmem_err"},   bus.o_dmem_err,   0);
    chk({where, " dmem_rdata"}, bus.o_dmem_rdata, 0);
    chk({where, " mem_req"},    bus.o_mem_req,    0);
    chk({where, " mem_wen"},    bus.o_mem_wen,    0);
    chk({where, " mem_addr"},   bus.o_mem_addr,   0);
    chk({where, " mem_wdata"},  bus.o_mem_wdata,  0);
    chk({where, " mem_mask"},   bus.o_mem_mask,   0);
    chk({where, " busy"},       bus.o_busy,       0);
  endtask

  // One single-requester transaction. rw: wait cycles before i_mem_ready
  // (-1 never); vw: cycles from ready to valid (0 same cycle, -1 never);
  // xv/xr: cycle of an extra stray valid/ready pulse (-1 none).
  // k counts cycles from capture (k=0).
  typedef struct {
    logic        is_fetch;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    int          rw;
    int          vw;
    int          xv;
    int          xr;
    logic [31:0] mem_rdata;
    logic        exp_wen;
    int          exp_req_cycles;
    int          exp_resp_k;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  logic exp_d [4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            fetch ren  wen  addr          wdata         mask     rw  vw  xv  xr  mem_rdata     wen  req resp err  rdata
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0,        4'h0,    0,  1, -1, -1, 32'h0000_0013, 1'b0, 1, 2, 1'b0, 32'h0000_0013};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0000_3000, 32'h0,        4'hF,    4,  2,  2,  6, 32'hDEAD_BEEF, 1'b0, 5, 7, 1'b0, 32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0000_2000, 32'hAB00_0000, 4'b1000, 0,  1, -1, -1, 32'h0,        1'b1, 1, 2, 1'b0, 32'h0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h0000_3004, 32'h0,        4'hF,    2,  0, -1, -1, 32'hCAFE_F00D, 1'b0, 3, 3, 1'b0, 32'hCAFE_F00D};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h0000_3008, 32'h0,        4'hF,   -1, -1, -1, -1, 32'h1234_5678, 1'b0, 7, 8, 1'b1, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'h0,        4'h0,    1, -1, -1, -1, 32'h8765_4321, 1'b0, 2, 8, 1'b1, 32'h0};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 32'h0000_300C, 32'h11,       4'hF,   -1, -1, -1, -1, 32'hFFFF_FFFF, 1'b0, 0, 1, 1'b1, 32'h0};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 32'h0000_0108, 32'h0,        4'h0,    0,  6, -1, -1, 32'h0050_0093, 1'b0, 1, 7, 1'b0, 32'h0050_0093};

`ifdef MEM_ARB_RR_EN
    exp_d[0] = 1'b1; exp_d[1] = 1'b0; exp_d[2] = 1'b1; exp_d[3] = 1'b0;
`else
    exp_d[0] = 1'b1; exp_d[1] = 1'b1; exp_d[2] = 1'b1; exp_d[3] = 1'b1;
`endif

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    tag = -1; cyc = 0;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    $display("txn reset: outputs checked in reset");

    // ---------------- table-driven transactions ----------------
    for (int v = 0; v < NV; v++) begin
      tag = v;
      for (int k = 0; k <= vecs[v].exp_resp_k + 1; k++) begin
        @(posedge clk); #1;
        cyc = k;
        bus.i_imem_req   = (k == 0) && vecs[v].is_fetch;
        bus.i_imem_addr  = vecs[v].addr;
        bus.i_dmem_ren   = (k == 0) && vecs[v].ren;
        bus.i_dmem_wen   = (k == 0) && vecs[v].wen;
        bus.i_dmem_addr  = vecs[v].addr;
        bus.i_dmem_wdata = vecs[v].wdata;
        bus.i_dmem_mask  = vecs[v].mask;
        bus.i_mem_ready  = ((vecs[v].rw >= 0) && (k == 1 + vecs[v].rw)) || (k == vecs[v].xr);
        bus.i_mem_valid  = ((vecs[v].rw >= 0) && (vecs[v].vw >= 0) &&
                            (k == 1 + vecs[v].rw + vecs[v].vw)) || (k == vecs[v].xv);
        bus.i_mem_rdata  = vecs[v].mem_rdata;
        @(negedge clk);
        chk("imem_ready", bus.o_imem_ready, (k == 0) && vecs[v].is_fetch);
        chk("dmem_ready", bus.o_dmem_ready, (k == 0) && !vecs[v].is_fetch);
        chk("mem_req",    bus.o_mem_req,    (k >= 1) && (k <= vecs[v].exp_req_cycles));
        chk("busy",       bus.o_busy,       (k >= 1) && (k <= vecs[v].exp_resp_k));
        chk("imem_valid", bus.o_imem_valid, (k == vecs[v].exp_resp_k) && vecs[v].is_fetch);
        chk("dmem_valid", bus.o_dmem_valid, (k == vecs[v].exp_resp_k) && !vecs[v].is_fetch);
        if (k == vecs[v].exp_resp_k) begin
          if (vecs[v].is_fetch) begin
            chk("imem_err",   bus.o_imem_err,   vecs[v].exp_err);
            chk("imem_rdata", bus.o_imem_rdata, vecs[v].exp_rdata);
          end else begin
            chk("dmem_err",   bus.o_dmem_err,   vecs[v].exp_err);
            chk("dmem_rdata", bus.o_dmem_rdata, vecs[v].exp_rdata);
          end
        end
        if ((k == 1) && (vecs[v].exp_req_cycles > 0)) begin
          chk("mem_addr", bus.o_mem_addr, vecs[v].addr);
          chk("mem_wen",  bus.o_mem_wen,  vecs[v].exp_wen);
          if (!vecs[v].is_fetch) begin
            chk("mem_wdata", bus.o_mem_wdata, vecs[v].wdata);
            chk("mem_mask",  bus.o_mem_mask,  vecs[v].mask);
          end
        end
      end
      $display("txn %0d: %s addr=0x%08h resp at k=%0d err=%0b, checks=%0d errors=%0d",
               v, vecs[v].is_fetch ? "fetch" : (vecs[v].wen ? (vecs[v].ren ? "illegal" : "store") : "load"),
               vecs[v].addr, vecs[v].exp_resp_k, vecs[v].exp_err, checks, errors);
    end

    // ---------------- fetch + store tie ----------------
    tag = 100;
    @(posedge clk); #1; cyc = 0;
    drive_idle();
    bus.i_imem_req   = 1'b1;
    bus.i_imem_addr  = 32'h0000_0400;
    bus.i_dmem_wen   = 1'b1;
    bus.i_dmem_addr  = 32'h0000_2000;
    bus.i_dmem_wdata = 32'hAB00_0000;
    bus.i_dmem_mask  = 4'b1000;
    @(negedge clk);
    chk("tie dmem_ready", bus.o_dmem_ready, 1);
    chk("tie imem_ready", bus.o_imem_ready, 0);
    @(posedge clk); #1; cyc = 1;
    bus.i_dmem_wen  = 1'b0;
    bus.i_mem_ready = 1'b1;
    @(negedge clk);
    chk("tie mem_req",   bus.o_mem_req,   1);
    chk("tie mem_wen",   bus.o_mem_wen,   1);
    chk("tie mem_addr",  bus.o_mem_addr,  32'h0000_2000);
    chk("tie mem_wdata", bus.o_mem_wdata, 32'hAB00_0000);
    chk("tie mem_mask",  bus.o_mem_mask,  4'b1000);
    chk("tie imem_ready held", bus.o_imem_ready, 0);
    @(posedge clk); #1; cyc = 2;
    bus.i_mem_ready = 1'b0;
    bus.i_mem_valid = 1'b1;
    @(negedge clk);
    chk("tie dmem_valid", bus.o_dmem_valid, 1);
    chk("tie dmem_err",   bus.o_dmem_err,   0);
    chk("tie imem_valid", bus.o_imem_valid, 0);
    @(posedge clk); #1; cyc = 3;
    bus.i_mem_valid = 1'b0;
    @(negedge clk);
    chk("tie fetch imem_ready", bus.o_imem_ready, 1);
    chk("tie fetch busy",       bus.o_busy,       0);
    @(posedge clk); #1; cyc = 4;
    bus.i_imem_req  = 1'b0;
    bus.i_mem_ready = 1'b1;
    @(negedge clk);
    chk("tie fetch mem_addr", bus.o_mem_addr, 32'h0000_0400);
    chk("tie fetch mem_wen",  bus.o_mem_wen,  0);
    @(posedge clk); #1; cyc = 5;
    bus.i_mem_ready = 1'b0;
    bus.i_mem_valid = 1'b1;
    bus.i_mem_rdata = 32'h0000_0513;
    @(negedge clk);
    chk("tie fetch imem_valid", bus.o_imem_valid, 1);
    chk("tie fetch imem_rdata", bus.o_imem_rdata, 32'h0000_0513);
    $display("txn tie: store first then fetch, checks=%0d errors=%0d", checks, errors);

    // ---------------- continuous ties ----------------
    tag = 200;
    for (int t = 0; t < 4; t++) begin
      @(posedge clk); #1; cyc = 0;
      drive_idle();
      bus.i_imem_req  = 1'b1;
      bus.i_imem_addr = 32'h0000_0500;
      bus.i_dmem_ren  = 1'b1;
      bus.i_dmem_addr = 32'h0000_4000;
      bus.i_dmem_mask = 4'hF;
      @(negedge clk);
      chk("rr dmem_ready", bus.o_dmem_ready, exp_d[t]);
      chk("rr imem_ready", bus.o_imem_ready, !exp_d[t]);
      @(posedge clk); #1; cyc = 1;
      bus.i_mem_ready = 1'b1;
      @(negedge clk);
      chk("rr mem_addr", bus.o_mem_addr, exp_d[t] ? 32'h0000_4000 : 32'h0000_0500);
      @(posedge clk); #1; cyc = 2;
      bus.i_mem_ready = 1'b0;
      bus.i_mem_valid = 1'b1;
      bus.i_mem_rdata = 32'h1000 + t;
      @(negedge clk);
      chk("rr dmem_valid", bus.o_dmem_valid, exp_d[t]);
      chk("rr imem_valid", bus.o_imem_valid, !exp_d[t]);
      $display("txn tie-stream %0d: grant %s, checks=%0d errors=%0d",
               t, exp_d[t] ? "data" : "fetch", checks, errors);
    end

    // ---------------- reset during RESP ----------------
    tag = 300;
    @(posedge clk); #1; cyc = 0;
    drive_idle();
    bus.i_dmem_ren  = 1'b1;
    bus.i_dmem_addr = 32'h0000_5000;
    bus.i_dmem_mask = 4'hF;
    @(negedge clk);
    chk("rst dmem_ready", bus.o_dmem_ready, 1);
    @(posedge clk); #1; cyc = 1;
    bus.i_dmem_ren  = 1'b0;
    bus.i_mem_ready = 1'b1;
    @(negedge clk);
    chk("rst mem_req", bus.o_mem_req, 1);
    @(posedge clk); #1; cyc = 2;
    bus.i_mem_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst busy in RESP", bus.o_busy, 1);
    chk("rst no dmem_valid", bus.o_dmem_valid, 0);
    @(posedge clk); #1; cyc = 3;
    rst_n = 1'b1;
    bus.i_mem_valid = 1'b1;
    bus.i_mem_rdata = 32'h0000_0077;
    @(negedge clk);
    chk_all_zero("rst late valid");
    @(posedge clk); #1; cyc = 4;
    bus.i_mem_valid = 1'b0;
    @(negedge clk);
    chk("rst after busy", bus.o_busy, 0);
    chk("rst after dmem_valid", bus.o_dmem_valid, 0);
    $display("txn reset-abort: checks=%0d errors=%0d", checks, errors);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
